// File: rtl/gigatron_pkg.sv
// Shared definitions for the Gigatron OUT-port to VGA front end:
// OUT-byte bit positions, the sync-lock state encoding and default timing.
package gigatron_pkg;

  // Gigatron OUT byte layout: [7] vsync_n, [6] hsync_n, [5:4] B, [3:2] G, [1:0] R
  localparam int VSYNC_BIT = 7;
  localparam int HSYNC_BIT = 6;
  localparam int B_LSB     = 4;
  localparam int G_LSB     = 2;
  localparam int R_LSB     = 0;
  localparam int NUM_CH    = 3;

  // Idle OUT byte: both syncs inactive (high), black
  localparam logic [7:0] OUT_IDLE = 8'hC0;

  // Default timing, in ce units horizontally and lines vertically
  localparam int H_START_DEF  = 36;
  localparam int V_START_DEF  = 35;
  localparam int H_ACTIVE_DEF = 160;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    HLOCK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/gigatron_vga_expand.sv
// One colour channel: 2-bit Gigatron level to 4-bit VGA level by bit
// replication. Optional macro GIGATRON_VGA_SCANLINE_EN halves the level
// when 'half' is set (odd lines), giving a scanline look.
module gigatron_vga_expand (
  input  logic [1:0] c2,
  input  logic       half,
  output logic [3:0] c4
);

`ifdef GIGATRON_VGA_SCANLINE_EN
  // {c2,c2} >> 1 on darkened lines, full level otherwise
  always_comb c4 = half ? {1'b0, c2, c2[1]} : {c2, c2};
`else
  logic unused_half;
  assign unused_half = half;
  // 00->0, 01->5, 10->A, 11->F
  always_comb c4 = {c2, c2};
`endif

endmodule

// File: rtl/gigatron_vga.sv
// Gigatron OUT-port to VGA: samples the CPU OUT byte on each ce strobe,
// recovers pixel position from the embedded syncs, locks onto the frame
// and drives registered RGB444 / sync / de / coordinate outputs.
// Optional feature: GIGATRON_VGA_SCANLINE_EN (halve colour on odd lines).
module gigatron_vga
  import gigatron_pkg::*;
#(
  parameter int H_START  = H_START_DEF,
  parameter int V_START  = V_START_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] vga,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [7:0] x,
  output logic [8:0] y,
  output logic       frame,
  output logic       locked
);

  localparam logic [7:0] H_OFF = 8'(H_START);
  localparam logic [9:0] V_OFF = 10'(V_START);

  logic [7:0]  in_q, prev;
  logic [7:0]  hcnt;
  logic [9:0]  vcnt;
  lock_state_t state, state_nx;
  logic        hfall, vfall, hsat_hit, is_locked;

  // Sync edges are only meaningful on ce clocks (the only time in_q moves)
  assign hfall = prev[HSYNC_BIT] & ~in_q[HSYNC_BIT];
  assign vfall = prev[VSYNC_BIT] & ~in_q[VSYNC_BIT];
  // hcnt is about to saturate: no hsync for a whole line-and-a-bit
  assign hsat_hit = ce & ~hfall & (hcnt == 8'd254);

  // Capture the OUT byte and its predecessor on each ce strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q <= OUT_IDLE;
      prev <= OUT_IDLE;
    end else if (ce) begin
      in_q <= vga;
      prev <= in_q;
    end
  end

  // Position counters, aligned with the sample now held in in_q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt <= 8'hFF;
      vcnt <= 10'h3FF;
    end else if (ce) begin
      if (hfall)              hcnt <= 8'd0;
      else if (hcnt != 8'hFF) hcnt <= hcnt + 8'd1;
      if (vfall)                         vcnt <= 10'd0;
      else if (hfall && vcnt != 10'h3FF) vcnt <= vcnt + 10'd1;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_nx;
  end

  // Lock FSM next state: hsync then vsync to lock, lost hsync drops it
  always_comb begin
    state_nx = state;
    if (ce) begin
      case (state)
        UNLOCKED: if (hfall) state_nx = HLOCK;
        HLOCK:    if (vfall) state_nx = LOCKED;
        LOCKED:   state_nx = state;
        default:  state_nx = UNLOCKED;
      endcase
    end
    if (hsat_hit) state_nx = UNLOCKED;
  end

  // Lock FSM outputs
  always_comb is_locked = (state == LOCKED);

  // Stage 1: active-area decode and coordinate offsets
  logic       h_in, v_in, de_c;
  logic [7:0] x_c;
  logic [9:0] y_full;
  logic       unused_ybit;

  assign h_in = (int'(hcnt) >= H_START) && (int'(hcnt) < H_START + H_ACTIVE);
  assign v_in = (int'(vcnt) >= V_START) && (int'(vcnt) < V_START + V_ACTIVE);
  assign de_c = is_locked & h_in & v_in;
  assign x_c    = hcnt - H_OFF;
  assign y_full = vcnt - V_OFF;
  assign unused_ybit = y_full[9];

  logic [5:0] s1_px;
  logic       s1_hs, s1_vs, s1_de;
  logic [7:0] s1_x;
  logic [8:0] s1_y;

  // First output pipeline stage (decoded position plus raw colour/syncs)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_px <= 6'd0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      s1_de <= 1'b0;
      s1_x  <= 8'd0;
      s1_y  <= 9'd0;
    end else begin
      s1_px <= in_q[B_LSB+1:R_LSB];
      s1_hs <= in_q[HSYNC_BIT];
      s1_vs <= in_q[VSYNC_BIT];
      s1_de <= de_c;
      s1_x  <= de_c ? x_c : 8'd0;
      s1_y  <= de_c ? y_full[8:0] : 9'd0;
    end
  end

  // Per-channel expansion: R, G, B share one sub-module
  logic [NUM_CH-1:0][1:0] c2;
  logic [NUM_CH-1:0][3:0] c4;
  logic                   show;

  assign c2 = s1_px;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    gigatron_vga_expand u_exp (
      .c2   (c2[ch]),
      .half (s1_y[0]),
      .c4   (c4[ch])
    );
  end

  // Gate with the live lock state so a lock loss blanks on the next clock
  assign show = s1_de & is_locked;

  // Output pins, registered every clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r      <= 4'd0;
      g      <= 4'd0;
      b      <= 4'd0;
      hs     <= 1'b1;
      vs     <= 1'b1;
      de     <= 1'b0;
      x      <= 8'd0;
      y      <= 9'd0;
      frame  <= 1'b0;
      locked <= 1'b0;
    end else begin
      r      <= show ? c4[0] : 4'd0;
      g      <= show ? c4[1] : 4'd0;
      b      <= show ? c4[2] : 4'd0;
      hs     <= s1_hs;
      vs     <= s1_vs;
      de     <= show;
      x      <= show ? s1_x : 8'd0;
      y      <= show ? s1_y : 9'd0;
      frame  <= ce & vfall & is_locked;
      locked <= is_locked;
    end
  end

endmodule

// File: tb/tb_gigatron_vga.sv
// Directed bench for gigatron_vga. Horizontal timing is the real Gigatron
// line (200 ce, hsync_n low for 24 ce); vertical timing is shrunk to an
// 8-line frame (vsync_n low on lines 0-1, active lines 2..5) to keep runs short.
module tb_gigatron_vga;

  localparam int V_S = 2;
  localparam int V_A = 4;
`ifdef GIGATRON_VGA_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce    = 1'b0;
  logic [7:0] vga   = 8'hC0;
  logic [3:0] r, g, b;
  logic       hs, vs, de, frame, locked;
  logic [7:0] x;
  logic [8:0] y;

  int total = 0;
  int passed = 0;
  int frame_cnt = 0;
  int cnt5 = 0;
  int cyc = 0;
  int t15 = -100;
  int first5 = -1;
  bit special = 1'b0;

  gigatron_vga #(
    .H_START  (36),
    .V_START  (V_S),
    .H_ACTIVE (160),
    .V_ACTIVE (V_A)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .vga    (vga),
    .r      (r),
    .g      (g),
    .b      (b),
    .hs     (hs),
    .vs     (vs),
    .de     (de),
    .x      (x),
    .y      (y),
    .frame  (frame),
    .locked (locked)
  );

  always #5 clock = ~clock;

  // Monitor: frame pulse clocks, clocks showing colour 5, 0x15 latency
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (frame) frame_cnt <= frame_cnt + 1;
    if (de && r == 4'h5 && g == 4'h5 && b == 4'h5) begin
      cnt5 <= cnt5 + 1;
      if (first5 < 0) first5 <= cyc;
    end
    if (ce && vga[5:0] == 6'h15) t15 <= cyc;
  end

  // One CPU OUT sample: ce for one clock, then three idle clocks.
  // Returns at the negedge after the second clock following the ce edge.
  task automatic put(input logic [7:0] v);
    @(negedge clock); ce = 1'b1; vga = v;
    @(negedge clock); ce = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  function automatic logic [7:0] line_byte(input int l, input int j, input logic [5:0] pix);
    line_byte = {(l >= 2) ? 1'b1 : 1'b0, (j >= 24) ? 1'b1 : 1'b0, pix};
  endfunction

  // Send n samples of line l; when chk, compare all pins after each sample
  task automatic send_line(input int l, input int n, input bit chk);
    logic [5:0] pix;
    logic [7:0] v, ex;
    logic [8:0] ey;
    logic [3:0] ec;
    logic       ed, el;
    for (int j = 0; j < n; j++) begin
      pix = (special && l == 2 && j == 37) ? 6'h15 : 6'h3F;
      v = line_byte(l, j, pix);
      put(v);
      if (chk) begin
        // hcnt = j-1 within the line, vcnt = line number
        ed = (j >= 37 && j <= 196 && l >= V_S && l < V_S + V_A);
        ex = ed ? 8'(j - 37) : 8'd0;
        ey = ed ? 9'(l - V_S) : 9'd0;
        ec = !ed ? 4'h0 : (pix == 6'h15) ? 4'h5 : (SCAN && ey[0]) ? 4'h7 : 4'hF;
        el = !(l == 0 && j == 0);
        total++;
        if ({de, x, y, r, g, b, hs, vs, locked} !== {ed, ex, ey, ec, ec, ec, v[6], v[7], el})
          $display("FAIL pixel line=%0d j=%0d: got de=%b x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b lk=%b, want de=%b x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b lk=%b",
                   l, j, de, x, y, r, g, b, hs, vs, locked, ed, ex, ey, ec, ec, ec, v[6], v[7], el);
        else passed++;
      end
    end
  endtask

  task automatic send_frame(input bit chk);
    for (int l = 0; l < 8; l++) send_line(l, 200, chk);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check1("reset r", 16'(r), 16'h0);
    check1("reset g", 16'(g), 16'h0);
    check1("reset b", 16'(b), 16'h0);
    check1("reset hs", 16'(hs), 16'h1);
    check1("reset vs", 16'(vs), 16'h1);
    check1("reset de", 16'(de), 16'h0);
    check1("reset x", 16'(x), 16'h0);
    check1("reset y", 16'(y), 16'h0);
    check1("reset frame", 16'(frame), 16'h0);
    check1("reset locked", 16'(locked), 16'h0);
    reset = 1'b0;
  endtask

  // hsync only: must never lock or show video; hs follows the input
  task automatic test_no_vsync();
    logic [7:0] v;
    int bad;
    bad = 0;
    for (int l = 0; l < 3; l++)
      for (int j = 0; j < 200; j++) begin
        v = line_byte(5, j, 6'h3F);
        put(v);
        total++;
        if (locked !== 1'b0 || de !== 1'b0 || hs !== v[6]) begin
          $display("FAIL no_vsync l=%0d j=%0d: got lk=%b de=%b hs=%b want lk=0 de=0 hs=%b",
                   l, j, locked, de, hs, v[6]);
          bad++;
        end else passed++;
      end
  endtask

  task automatic test_frame();
    do_reset();
    special = 1'b0;
    send_frame(1'b0);                   // first vfall only reaches HLOCK
    check1("locked after frame0", 16'(locked), 16'h0);
    special = 1'b1;
    send_frame(1'b1);                   // locked from line 0 sample 1 on
    special = 1'b0;
    check1("colour5 clocks", 16'(cnt5), 16'd4);
    check1("colour5 latency", 16'(first5 - t15 - 1), 16'd2);
    check1("no pulse on locking vfall", 16'(frame_cnt), 16'd0);
    send_line(0, 200, 1'b0);            // hfall and vfall on the same ce
    check1("single frame pulse", 16'(frame_cnt), 16'd1);
    send_line(1, 200, 1'b1);
    send_line(2, 200, 1'b1);
  endtask

  task automatic test_lock_loss();
    logic [7:0] v;
    for (int j = 0; j < 260; j++) begin
      v = line_byte(3, j, 6'h3F);
      put(v);
      if (j == 255) check1("locked at hcnt 254", 16'(locked), 16'h1);
      if (j == 256) begin
        check1("locked drop at hcnt 255", 16'(locked), 16'h0);
        check1("de after lock loss", 16'(de), 16'h0);
        check1("r after lock loss", 16'(r), 16'h0);
      end
    end
    for (int l = 4; l < 8; l++) send_line(l, 200, 1'b0);
    check1("locked before relock vfall", 16'(locked), 16'h0);
    send_frame(1'b1);                   // relock frame, same shape as frame 1
    check1("no pulse while relocking", 16'(frame_cnt), 16'd1);
    send_line(0, 200, 1'b0);
    check1("pulse after relock", 16'(frame_cnt), 16'd2);
  endtask

  task automatic test_reset_midframe();
    send_line(1, 200, 1'b1);
    send_line(2, 200, 1'b1);
    send_line(3, 100, 1'b1);
    check1("de before mid reset", 16'(de), 16'h1);
    #2 reset = 1'b1;
    #1;
    check1("async reset de", 16'(de), 16'h0);
    check1("async reset r", 16'(r), 16'h0);
    check1("async reset locked", 16'(locked), 16'h0);
    check1("async reset x", 16'(x), 16'h0);
    @(negedge clock); reset = 1'b0;
    for (int l = 4; l < 8; l++) send_line(l, 200, 1'b0);
    check1("locked needs vfall after reset", 16'(locked), 16'h0);
    send_line(0, 200, 1'b0);
    check1("relocked after reset", 16'(locked), 16'h1);
    check1("no pulse on relock", 16'(frame_cnt), 16'd2);
    send_line(1, 200, 1'b1);
    send_line(2, 200, 1'b1);
  endtask

  initial begin
    test_reset();
    test_no_vsync();
    test_frame();
    test_lock_loss();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
